motor_sequencer: RTL and testbench

Controller that sequences the gate motor for a full open/hold/close cycle and shares it between two requesters: the RFID reader (`rf_req`) and the manual push-button (`btn_req`). It arbitrates requests, drives motor enable and direction, stops on limit switches, runs a run-time watchdog, and latches faults. It sits between the input conditioning logic and the motor driver pins.

---
 rtl/motor_pkg.sv | 25 ++
 rtl/motor_sequencer_req_edge.sv | 33 +++
 rtl/motor_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_motor_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared types and default constants for the gate motor sequencer.
//   motor_state_t    : sequencer state encoding
//   HOLD_CYCLES_DEF  : default number of cycles the gate stays open
//   RUN_TIMEOUT_DEF  : default maximum cycles allowed while the motor runs
//   CNT_W_DEF        : default state counter width
//   is_moving()      : true in the states that drive the motor
package motor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPENING = 3'd1,
        ST_HOLD    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_FAULT   = 3'd4
    } motor_state_t;

    localparam int unsigned HOLD_CYCLES_DEF = 32'd50_000_000;
    localparam int unsigned RUN_TIMEOUT_DEF = 32'd200_000_000;
    localparam int unsigned CNT_W_DEF       = 32'd28;

    function automatic logic is_moving(input motor_state_t s);
        return (s == ST_OPENING) || (s == ST_CLOSING);
    endfunction

endpackage

// File: rtl/motor_sequencer_req_edge.sv
// req_edge: rising-edge detector for one requester level.
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   lvl_i  : request level, already synchronous to clk
//   rise_o : high in the cycle where lvl_i is high and was low at the previous sample
module req_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic lvl_i,
    output logic rise_o
);

    logic prev_q;
    logic prev_d;

    // Next value of the level history.
    always_comb begin
        prev_d = lvl_i;
    end

    // History register. While reset is held it tracks the level, so a level
    // that stays high across reset release does not look like a new edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= lvl_i;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/motor_sequencer.sv
// motor_sequencer: open/hold/close gate motor sequencer shared by an RFID
// reader and a push-button, with limit-switch stops, estop and fault latch.
//   clk, rst_n            : clock, synchronous active-low reset
//   rf_req, btn_req       : request levels (rising edge = request, rf wins)
//   lim_open, lim_closed  : limit switches
//   estop                 : emergency stop level, highest priority
//   motor_en, motor_dir   : motor drive enable, direction (1 = open)
//   busy, fault           : not-IDLE, in-FAULT status
//   grant_rf, grant_btn   : one-cycle accept pulses
// Optional feature macro: MOTOR_SEQ_TIMEOUT_EN enables the run-time watchdog.
// All outputs are registered; they reflect the state chosen at the last edge.
import motor_pkg::*;

module motor_sequencer #(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned RUN_TIMEOUT = RUN_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rf_req,
    input  logic btn_req,
    input  logic lim_open,
    input  logic lim_closed,
    input  logic estop,
    output logic motor_en,
    output logic motor_dir,
    output logic busy,
    output logic fault,
    output logic grant_rf,
    output logic grant_btn
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // Reject a counter too narrow to reach either terminal count.
    if (((64'd1 << CNT_W) <= 64'(HOLD_CYCLES)) || ((64'd1 << CNT_W) <= 64'(RUN_TIMEOUT))) begin : g_bad_cnt_w
        $error("motor_sequencer: CNT_W too narrow for HOLD_CYCLES/RUN_TIMEOUT");
    end

`ifdef MOTOR_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_TIMEOUT - 32'd1);
`endif

    motor_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_restart_s;
    logic             motor_en_q, motor_en_d;
    logic             motor_dir_q, motor_dir_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;
    logic             grant_rf_q, grant_rf_d;
    logic             grant_btn_q, grant_btn_d;
    logic             rf_rise_s, btn_rise_s, any_rise_s;

    req_edge u_rf_edge  (.clk(clk), .rst_n(rst_n), .lvl_i(rf_req),  .rise_o(rf_rise_s));
    req_edge u_btn_edge (.clk(clk), .rst_n(rst_n), .lvl_i(btn_req), .rise_o(btn_rise_s));

    assign any_rise_s = rf_rise_s | btn_rise_s;

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            motor_en_q  <= 1'b0;
            motor_dir_q <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            grant_rf_q  <= 1'b0;
            grant_btn_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            motor_en_q  <= motor_en_d;
            motor_dir_q <= motor_dir_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            grant_rf_q  <= grant_rf_d;
            grant_btn_q <= grant_btn_d;
        end
    end

    // Next state, grants and counter.
    always_comb begin
        state_d       = state_q;
        cnt_restart_s = 1'b0;
        grant_rf_d    = 1'b0;
        grant_btn_d   = 1'b0;
        if (estop) begin
            state_d = ST_FAULT;
        end else if ((state_q != ST_FAULT) && lim_open && lim_closed) begin
            // Both limits at once means a broken switch or harness.
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_rise_s) begin
                        if (rf_rise_s) begin
                            grant_rf_d = 1'b1;
                        end else begin
                            grant_btn_d = 1'b1;
                        end
                        state_d = lim_open ? ST_HOLD : ST_OPENING;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_OPENING: begin
                    if (lim_open) begin
                        state_d = ST_HOLD;
`ifdef MOTOR_SEQ_TIMEOUT_EN
                    end else if (cnt_q == RUN_LAST) begin
                        state_d = ST_FAULT;
`endif
                    end else begin
                        state_d = ST_OPENING;
                    end
                end
                ST_HOLD: begin
                    // A request beats expiry so a late arrival still keeps the gate open.
                    if (any_rise_s) begin
                        cnt_restart_s = 1'b1;
                        if (rf_rise_s) begin
                            grant_rf_d = 1'b1;
                        end else begin
                            grant_btn_d = 1'b1;
                        end
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = ST_CLOSING;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_CLOSING: begin
                    if (lim_closed) begin
                        state_d = ST_IDLE;
                    end else if (any_rise_s) begin
                        state_d = ST_OPENING;
                        if (rf_rise_s) begin
                            grant_rf_d = 1'b1;
                        end else begin
                            grant_btn_d = 1'b1;
                        end
`ifdef MOTOR_SEQ_TIMEOUT_EN
                    end else if (cnt_q == RUN_LAST) begin
                        state_d = ST_FAULT;
`endif
                    end else begin
                        state_d = ST_CLOSING;
                    end
                end
                ST_FAULT: begin
                    // Only the local button may clear a fault; estop is already low here.
                    if (btn_rise_s) begin
                        state_d     = ST_IDLE;
                        grant_btn_d = 1'b1;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end

        // Counter clears on any state change or hold extension and saturates.
        if ((state_d != state_q) || cnt_restart_s) begin
            cnt_d = '0;
        end else if (is_moving(state_q) || (state_q == ST_HOLD)) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs decoded from the next state so they are valid right after the edge.
    always_comb begin
        motor_en_d  = is_moving(state_d);
        motor_dir_d = (state_d == ST_OPENING);
        busy_d      = (state_d != ST_IDLE);
        fault_d     = (state_d == ST_FAULT);
    end

    assign motor_en  = motor_en_q;
    assign motor_dir = motor_dir_q;
    assign busy      = busy_q;
    assign fault     = fault_q;
    assign grant_rf  = grant_rf_q;
    assign grant_btn = grant_btn_q;

endmodule

// File: tb/tb_motor_sequencer.sv
// tb_motor_sequencer: directed self-checking bench for motor_sequencer with
// HOLD_CYCLES=4, RUN_TIMEOUT=8. The watchdog section follows MOTOR_SEQ_TIMEOUT_EN.
module tb_motor_sequencer;

    logic clk = 1'b0;
    logic rst_n, rf_req, btn_req, lim_open, lim_closed, estop;
    logic motor_en, motor_dir, busy, fault, grant_rf, grant_btn;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    always #5 clk = ~clk;

    motor_sequencer #(
        .HOLD_CYCLES(32'd4),
        .RUN_TIMEOUT(32'd8),
        .CNT_W(32'd8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rf_req(rf_req), .btn_req(btn_req),
        .lim_open(lim_open), .lim_closed(lim_closed), .estop(estop),
        .motor_en(motor_en), .motor_dir(motor_dir), .busy(busy), .fault(fault),
        .grant_rf(grant_rf), .grant_btn(grant_btn)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one active edge, then sample away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pack outputs as {en,dir,busy,fault,grant_rf,grant_btn}.
    function automatic logic [31:0] outs();
        return {26'd0, motor_en, motor_dir, busy, fault, grant_rf, grant_btn};
    endfunction

    initial begin
        rst_n = 1'b0; rf_req = 1'b0; btn_req = 1'b0;
        lim_open = 1'b0; lim_closed = 1'b1; estop = 1'b0;
        tick(); tick();
        check_eq("reset_outs", outs(), 32'b000000);
        check_eq("reset_cnt", 32'(dut.cnt_q), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_outs", outs(), 32'b000000);

        // Full cycle
        lim_closed = 1'b0; rf_req = 1'b1;
        tick();
        check_eq("fc_grant", outs(), 32'b111010);
        rf_req = 1'b0;
        tick();
        check_eq("fc_open2", outs(), 32'b111000);
        tick();
        check_eq("fc_open3", outs(), 32'b111000);
        lim_open = 1'b1;
        tick();
        check_eq("fc_hold", outs(), 32'b001000);
        n = 0;
        while (motor_en == 1'b0 && n < 10) begin tick(); n++; end
        check_eq("fc_hold_len", 32'(n), 32'd4);
        check_eq("fc_closing", outs(), 32'b101000);
        lim_open = 1'b0;
        tick();
        lim_closed = 1'b1;
        tick();
        check_eq("fc_idle", outs(), 32'b000000);

        // Simultaneous edges
        rf_req = 1'b1; btn_req = 1'b1;
        tick();
        check_eq("sim_grant", outs(), 32'b111010);
        rf_req = 1'b0; btn_req = 1'b0; lim_closed = 1'b0; lim_open = 1'b1;
        tick();
        check_eq("sim_hold", outs(), 32'b001000);
        n = 0;
        while (motor_en == 1'b0 && n < 10) begin tick(); n++; end
        lim_open = 1'b0;
        check_eq("sim_closing", outs(), 32'b101000);

        // Re-open in the 2nd CLOSING cycle
        tick();
        btn_req = 1'b1;
        tick();
        check_eq("ro_grant", outs(), 32'b111001);
        check_eq("ro_cnt", 32'(dut.cnt_q), 32'd0);
        btn_req = 1'b0;
        tick();
        check_eq("ro_pulse_end", outs(), 32'b111000);

        // Hold extension
        lim_open = 1'b1;
        tick();
        tick();
        rf_req = 1'b1;
        tick();
        check_eq("ext_grant", outs(), 32'b001010);
        check_eq("ext_cnt", 32'(dut.cnt_q), 32'd0);
        rf_req = 1'b0;
        n = 0;
        while (motor_en == 1'b0 && n < 10) begin tick(); n++; end
        check_eq("ext_hold_len", 32'(n), 32'd4);
        lim_open = 1'b0; lim_closed = 1'b1;
        tick();
        check_eq("ext_idle", outs(), 32'b000000);

        // Watchdog
        btn_req = 1'b1;
        tick();
        lim_closed = 1'b0; btn_req = 1'b0;
`ifdef MOTOR_SEQ_TIMEOUT_EN
        rf_req = 1'b1;
        tick();
        check_eq("to_rf_ignored", outs(), 32'b111000);
        rf_req = 1'b0;
        n = 1;
        while (fault == 1'b0 && n < 20) begin tick(); n++; end
        check_eq("to_len", 32'(n), 32'd8);
        check_eq("to_fault", outs(), 32'b001100);
        rf_req = 1'b1;
        tick();
        check_eq("to_rf_in_fault", outs(), 32'b001100);
        rf_req = 1'b0;
`else
        for (int i = 0; i < 12; i++) tick();
        check_eq("nto_running", outs(), 32'b111000);
        estop = 1'b1;
        tick();
        check_eq("nto_estop", outs(), 32'b001100);
        estop = 1'b0;
`endif
        btn_req = 1'b1;
        tick();
        check_eq("fault_clear", 32'({busy, fault}), 32'b00);
        btn_req = 1'b0;

        // Estop during HOLD
        lim_open = 1'b1; rf_req = 1'b1;
        tick();
        check_eq("es_direct_hold", outs(), 32'b001010);
        rf_req = 1'b0;
        tick();
        estop = 1'b1;
        tick();
        check_eq("es_fault", outs(), 32'b001100);
        btn_req = 1'b1;
        tick();
        check_eq("es_btn_held", outs(), 32'b001100);
        btn_req = 1'b0;
        tick();
        estop = 1'b0;
        tick();
        check_eq("es_released", 32'(fault), 32'd1);
        btn_req = 1'b1;
        tick();
        check_eq("es_clear", 32'({busy, fault}), 32'b00);
        btn_req = 1'b0;

        // Both limits high
        lim_closed = 1'b1;
        tick();
        check_eq("both_lim", 32'(fault), 32'd1);
        lim_open = 1'b0; btn_req = 1'b1;
        tick();
        check_eq("both_lim_clear", 32'({busy, fault}), 32'b00);
        btn_req = 1'b0;

        // Reset mid-run
        lim_closed = 1'b0; rf_req = 1'b1;
        tick();
        check_eq("rst_opening", outs(), 32'b111010);
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("rst_outs", outs(), 32'b000000);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_eq("rst_held_level", 32'(busy), 32'd0);
        rf_req = 1'b0;
        tick();
        rf_req = 1'b1;
        tick();
        check_eq("rst_new_edge", outs(), 32'b111010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
